// File: rtl/im_fetch_if.sv
// AXI4 read-address / read-data channel bundle between the instruction-fetch
// master and instruction memory.
interface im_fetch_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/im_fetch_master.sv
// Instruction-fetch AXI4 read master: one single-beat read outstanding, flush drains.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module im_fetch_master #(
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  input  logic          fetch_en,
  input  logic          flush,
  input  logic          wfi,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          im_busy,
  output logic          resp_err,
  output logic          fetch_err,
  im_fetch_if.master    axi
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DROP} state_t;

  state_t      state, state_nxt;
  logic        arvalid_r, arvalid_nxt;
  logic        rready_r, rready_nxt;
  logic [31:0] araddr_r, araddr_nxt;
  logic [31:0] instr_nxt;
  logic        instr_valid_nxt, resp_err_nxt;
  logic        drop, drop_nxt;
  logic        beat_last;
  logic        abort;

  assign axi.arid    = ID_W'(AXI_ID);
  assign axi.araddr  = araddr_r;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_r;
  assign axi.rready  = rready_r;

  assign beat_last = axi.rvalid & rready_r & axi.rlast;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  logic [7:0] timer;

  // Abort fires in the cycle the timer reaches its last count; fetch_err follows a cycle later.
  assign abort = ((state == ADDR) || (state == DATA)) && !drop && !flush &&
                 !beat_last && (timer == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      timer     <= 8'd0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= abort;
      if (state == IDLE)
        timer <= 8'd0;
      else if (((state == ADDR) || (state == DATA)) && !drop)
        timer <= timer + 8'd1;
    end
  end
`else
  assign abort     = 1'b0;
  assign fetch_err = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{axi.rid, 32'(TIMEOUT)};

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    arvalid_nxt     = arvalid_r;
    rready_nxt      = rready_r;
    araddr_nxt      = araddr_r;
    instr_nxt       = instr;
    instr_valid_nxt = 1'b0;
    resp_err_nxt    = 1'b0;
    drop_nxt        = drop;
    im_busy         = 1'b0;

    case (state)
      IDLE: begin
        im_busy = fetch_en & ~wfi & ~flush;
        if (fetch_en && !wfi && !flush) begin
          araddr_nxt  = pc;
          arvalid_nxt = 1'b1;
          drop_nxt    = 1'b0;
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        // The address cannot be withdrawn once offered, so a flush only marks the read for draining.
        im_busy  = ~abort;
        drop_nxt = drop | flush | abort;
        if (axi.arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = (drop | flush | abort) ? DROP : DATA;
        end
      end
      DATA: begin
        im_busy = ~(beat_last & ~flush) & ~abort;
        if (beat_last) begin
          rready_nxt = 1'b0;
          state_nxt  = IDLE;
          if (!flush) begin
            instr_valid_nxt = 1'b1;
            if (axi.rresp == 2'b00) begin
              instr_nxt = axi.rdata;
            end else begin
              instr_nxt    = NOP;
              resp_err_nxt = 1'b1;
            end
          end
        end else if (flush || abort) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (beat_last) begin
          rready_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      instr_nxt       = NOP;
      instr_valid_nxt = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      araddr_r    <= 32'd0;
      instr       <= NOP;
      instr_valid <= 1'b0;
      resp_err    <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state       <= state_nxt;
      arvalid_r   <= arvalid_nxt;
      rready_r    <= rready_nxt;
      araddr_r    <= araddr_nxt;
      instr       <= instr_nxt;
      instr_valid <= instr_valid_nxt;
      resp_err    <= resp_err_nxt;
      drop        <= drop_nxt;
    end
  end
endmodule

// File: tb/tb_im_fetch_master.sv
// Directed bench for im_fetch_master: per-cycle vector table plus hand-written
// stall, flush and timeout sequences.
module tb_im_fetch_master;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_en, flush, wfi;
  logic [31:0] instr;
  logic        instr_valid, im_busy, resp_err, fetch_err;

  im_fetch_if #(.ID_W(4)) bus ();

  im_fetch_master #(.ID_W(4), .AXI_ID(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush), .wfi(wfi),
    .instr(instr), .instr_valid(instr_valid), .im_busy(im_busy),
    .resp_err(resp_err), .fetch_err(fetch_err), .axi(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic fe, input logic fl, input logic wf, input logic [31:0] p,
                     input logic ar, input logic rv, input logic [31:0] rd,
                     input logic [1:0] rr, input logic rl);
    @(negedge clk);
    fetch_en    = fe;
    flush       = fl;
    wfi         = wf;
    pc          = p;
    bus.arready = ar;
    bus.rvalid  = rv;
    bus.rdata   = rd;
    bus.rresp   = rr;
    bus.rlast   = rl;
    #1;
  endtask

  typedef struct {
    logic fe, fl, wf; logic [31:0] pc;
    logic ar, rv; logic [31:0] rd; logic [1:0] rr; logic rl;
    logic e_arv; logic [31:0] e_addr; logic e_rrdy, e_busy, e_iv;
    logic [31:0] e_instr; logic e_rerr;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // fe fl wf pc  ar rv rdata rresp rlast | arv addr rrdy busy iv instr rerr
    vecs[0]  = '{0,0,0,32'h0,   0,0,32'h0,        2'd0,0, 0,32'h0,  0,0,0,32'h13,       0};
    vecs[1]  = '{1,0,0,32'h100, 0,0,32'h0,        2'd0,0, 0,32'h0,  0,1,0,32'h13,       0};
    vecs[2]  = '{1,0,0,32'h100, 1,0,32'h0,        2'd0,0, 1,32'h100,0,1,0,32'h13,       0};
    vecs[3]  = '{0,0,0,32'h104, 0,1,32'h00500093, 2'd0,1, 0,32'h100,1,0,0,32'h13,       0};
    vecs[4]  = '{1,0,0,32'h104, 0,0,32'h0,        2'd0,0, 0,32'h100,0,1,1,32'h00500093, 0};
    vecs[5]  = '{1,0,0,32'h104, 1,0,32'h0,        2'd0,0, 1,32'h104,0,1,0,32'h00500093, 0};
    vecs[6]  = '{0,0,0,32'h0,   0,1,32'hBAD,      2'd2,1, 0,32'h104,1,0,0,32'h00500093, 0};
    vecs[7]  = '{0,1,0,32'h0,   0,0,32'h0,        2'd0,0, 0,32'h104,0,0,1,32'h13,       1};
    vecs[8]  = '{1,0,1,32'h200, 0,0,32'h0,        2'd0,0, 0,32'h104,0,0,0,32'h13,       0};
    vecs[9]  = '{1,1,0,32'h200, 0,0,32'h0,        2'd0,0, 0,32'h104,0,0,0,32'h13,       0};
    vecs[10] = '{0,0,0,32'h200, 0,0,32'h0,        2'd0,0, 0,32'h104,0,0,0,32'h13,       0};
    vecs[11] = '{1,0,0,32'h300, 0,0,32'h0,        2'd0,0, 0,32'h104,0,1,0,32'h13,       0};
    vecs[12] = '{0,0,1,32'h300, 1,0,32'h0,        2'd0,0, 1,32'h300,0,1,0,32'h13,       0};
    vecs[13] = '{0,0,1,32'h0,   0,1,32'h111,      2'd0,0, 0,32'h300,1,1,0,32'h13,       0};
    vecs[14] = '{0,0,1,32'h0,   0,1,32'h00A00113, 2'd0,1, 0,32'h300,1,0,0,32'h13,       0};
    vecs[15] = '{0,0,0,32'h0,   0,0,32'h0,        2'd0,0, 0,32'h300,0,0,1,32'h00A00113, 0};
    vecs[16] = '{0,0,0,32'h0,   0,0,32'h0,        2'd0,0, 0,32'h300,0,0,0,32'h00A00113, 0};

    bus.rid = 4'd0;
    rst = 1'b0;
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    @(posedge clk);
    #1;
    check("rst_arvalid", 32'(bus.arvalid), 32'd0);
    check("rst_rready",  32'(bus.rready),  32'd0);
    check("rst_araddr",  bus.araddr,       32'd0);
    check("rst_instr",   instr,            32'h13);
    check("rst_iv",      32'(instr_valid), 32'd0);
    check("rst_busy",    32'(im_busy),     32'd0);
    check("rst_ferr",    32'(fetch_err),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].fe, vecs[i].fl, vecs[i].wf, vecs[i].pc, vecs[i].ar,
          vecs[i].rv, vecs[i].rd, vecs[i].rr, vecs[i].rl);
      check($sformatf("v%0d_arvalid", i), 32'(bus.arvalid),   32'(vecs[i].e_arv));
      check($sformatf("v%0d_araddr", i),  bus.araddr,         vecs[i].e_addr);
      check($sformatf("v%0d_rready", i),  32'(bus.rready),    32'(vecs[i].e_rrdy));
      check($sformatf("v%0d_busy", i),    32'(im_busy),       32'(vecs[i].e_busy));
      check($sformatf("v%0d_iv", i),      32'(instr_valid),   32'(vecs[i].e_iv));
      check($sformatf("v%0d_instr", i),   instr,              vecs[i].e_instr);
      check($sformatf("v%0d_rerr", i),    32'(resp_err),      32'(vecs[i].e_rerr));
      check($sformatf("v%0d_ferr", i),    32'(fetch_err),     32'd0);
    end

    // Slave stall: address held 5 cycles, data 3 cycles late.
    cyc(1,0,0,32'h400, 0,0,0,2'd0,0);
    check("st_busy_req", 32'(im_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(1,0,0,32'h400, 0,0,0,2'd0,0);
      check($sformatf("st%0d_arvalid", i), 32'(bus.arvalid), 32'd1);
      check($sformatf("st%0d_araddr", i),  bus.araddr,       32'h400);
      check($sformatf("st%0d_busy", i),    32'(im_busy),     32'd1);
      if (i == 0) begin
        check("st_arlen",   32'(bus.arlen),   32'd0);
        check("st_arsize",  32'(bus.arsize),  32'd2);
        check("st_arburst", 32'(bus.arburst), 32'd1);
        check("st_arid",    32'(bus.arid),    32'd0);
      end
    end
    cyc(1,0,0,32'h400, 1,0,0,2'd0,0);
    check("st_arvalid_hs", 32'(bus.arvalid), 32'd1);
    check("st_busy_hs",    32'(im_busy),     32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0, 0,0,0,2'd0,0);
      check($sformatf("sd%0d_rready", i),  32'(bus.rready),  32'd1);
      check($sformatf("sd%0d_arvalid", i), 32'(bus.arvalid), 32'd0);
      check($sformatf("sd%0d_busy", i),    32'(im_busy),     32'd1);
      check($sformatf("sd%0d_iv", i),      32'(instr_valid), 32'd0);
    end
    cyc(0,0,0,0, 0,1,32'h1234,2'd0,1);
    check("st_busy_beat", 32'(im_busy), 32'd0);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    check("st_iv",    32'(instr_valid), 32'd1);
    check("st_instr", instr,            32'h1234);

    // Flush in DATA one cycle before RVALID.
    cyc(1,0,0,32'h500, 0,0,0,2'd0,0);
    check("fd_busy_req", 32'(im_busy), 32'd1);
    cyc(1,0,0,32'h500, 1,0,0,2'd0,0);
    cyc(0,1,0,0, 0,0,0,2'd0,0);
    check("fd_busy_flush", 32'(im_busy), 32'd1);
    cyc(0,0,0,0, 0,1,32'hDEADBEEF,2'd0,1);
    check("fd_rready_drop", 32'(bus.rready), 32'd1);
    check("fd_busy_drop",   32'(im_busy),    32'd0);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    check("fd_iv",     32'(instr_valid), 32'd0);
    check("fd_instr",  instr,            32'h1234);
    check("fd_rready", 32'(bus.rready),  32'd0);

    // Flush in ADDR while the slave stalls the address.
    cyc(1,0,0,32'h600, 0,0,0,2'd0,0);
    cyc(0,1,0,0, 0,0,0,2'd0,0);
    check("fa_arvalid", 32'(bus.arvalid), 32'd1);
    check("fa_busy",    32'(im_busy),     32'd1);
    cyc(0,0,0,0, 1,0,0,2'd0,0);
    cyc(0,0,0,0, 0,1,32'hAAAA,2'd0,1);
    check("fa_rready_drop", 32'(bus.rready), 32'd1);
    check("fa_busy_drop",   32'(im_busy),    32'd0);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    check("fa_iv",    32'(instr_valid), 32'd0);
    check("fa_instr", instr,            32'h1234);

    // Flush in the same cycle as the RLAST handshake.
    cyc(1,0,0,32'h700, 0,0,0,2'd0,0);
    cyc(1,0,0,32'h700, 1,0,0,2'd0,0);
    cyc(0,1,0,0, 0,1,32'hCAFE,2'd0,1);
    check("fs_busy", 32'(im_busy), 32'd1);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    check("fs_iv",     32'(instr_valid), 32'd0);
    check("fs_instr",  instr,            32'h1234);
    check("fs_rready", 32'(bus.rready),  32'd0);

    // Read data never arrives: watchdog abort (when built in), then a late beat.
    cyc(1,0,0,32'h800, 0,0,0,2'd0,0);
    cyc(0,0,0,0, 1,0,0,2'd0,0);
    check("to_arvalid", 32'(bus.arvalid), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      cyc(0,0,0,0, 0,0,0,2'd0,0);
      check($sformatf("to%0d_ferr", k),   32'(fetch_err),   32'(TMO && k == 8));
      check($sformatf("to%0d_iv", k),     32'(instr_valid), 32'(TMO && k == 8));
      check($sformatf("to%0d_busy", k),   32'(im_busy),     32'(!(TMO && k >= 7)));
      check($sformatf("to%0d_rready", k), 32'(bus.rready),  32'd1);
      if (k == 8)
        check("to_instr_abort", instr, TMO ? 32'h13 : 32'h1234);
    end
    cyc(0,0,0,0, 0,1,32'hBEEF,2'd0,1);
    check("to_busy_late", 32'(im_busy), 32'd0);
    cyc(0,0,0,0, 0,0,0,2'd0,0);
    check("to_iv_late",    32'(instr_valid), TMO ? 32'd0 : 32'd1);
    check("to_instr_late", instr,            TMO ? 32'h13 : 32'hBEEF);
    check("to_ferr_late",  32'(fetch_err),   32'd0);
    check("to_rready_end", 32'(bus.rready),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
